// File: rtl/match_controller.sv
// Pong match sequencer: serve/play/point/over FSM driving scores, countdown and winner.
// Define MATCH_CTRL_PAUSE_EN to add the `pause` input and the PAUSED state.
module match_controller #(
  parameter int SCREEN_W       = 640,
  parameter int FRAMES_PER_SEC = 60,
  parameter int SERVE_FRAMES   = 60,
  parameter int OVER_FRAMES    = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       start,
`ifdef MATCH_CTRL_PAUSE_EN
  input  logic       pause,
`endif
  input  logic [9:0] ball_x,
  input  logic [3:0] win_score,
  input  logic [5:0] time_limit,
  output logic [2:0] state,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [5:0] seconds,
  output logic       new_round,
  output logic       ball_enable,
  output logic       game_over,
  output logic [1:0] winner
);
  localparam int FMAX = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
  localparam int FCW  = $clog2(FMAX + 1);
  localparam int SCW  = $clog2(FRAMES_PER_SEC + 1);
  localparam logic [10:0] RIGHT_EDGE = 11'(SCREEN_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    POINT  = 3'd3,
    OVER   = 3'd4,
    PAUSED = 3'd5
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_score1, r_score2, w_score1_nxt, w_score2_nxt;
  logic [5:0]       r_seconds, w_seconds_nxt;
  logic [1:0]       r_winner, w_winner_nxt;
  logic             r_new_round, w_new_round_nxt;
  logic [FCW-1:0]   r_frame, w_frame_nxt;
  logic [SCW-1:0]   r_sub, w_sub_nxt;

  logic [3:0] w_win;
  logic [5:0] w_tlim;
  logic       w_p1_hit, w_p2_hit, w_hit, w_pause;
  logic [3:0] w_sc1, w_sc2;
  logic [5:0] w_sec_dec;
  logic [SCW-1:0] w_sub_adv;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  function automatic logic [1:0] compare_winner(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return 2'd1;
    if (b > a) return 2'd2;
    return 2'd3;
  endfunction

`ifdef MATCH_CTRL_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_win    = (win_score == 4'd0) ? 4'd1 : win_score;
  assign w_tlim   = (time_limit == 6'd0) ? 6'd1 : time_limit;
  assign w_p1_hit = ({1'b0, ball_x} >= RIGHT_EDGE);
  assign w_p2_hit = (ball_x == 10'd0);
  assign w_hit    = w_p1_hit | w_p2_hit;
  assign w_sc1    = w_p1_hit ? sat_inc(r_score1) : r_score1;
  assign w_sc2    = w_p2_hit ? sat_inc(r_score2) : r_score2;

  // One countdown step: sub-second counter wraps each second and pulls `seconds` down.
  always_comb begin
    w_sub_adv = r_sub + 1'b1;
    w_sec_dec = r_seconds;
    if (r_sub == SCW'(FRAMES_PER_SEC - 1)) begin
      w_sub_adv = '0;
      w_sec_dec = (r_seconds != 6'd0) ? r_seconds - 6'd1 : 6'd0;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_score1_nxt    = r_score1;
    w_score2_nxt    = r_score2;
    w_seconds_nxt   = r_seconds;
    w_winner_nxt    = r_winner;
    w_new_round_nxt = 1'b0;
    w_frame_nxt     = r_frame;
    w_sub_nxt       = r_sub;
    case (r_state)
      IDLE: begin
        w_score1_nxt  = 4'd0;
        w_score2_nxt  = 4'd0;
        w_winner_nxt  = 2'd0;
        w_seconds_nxt = w_tlim;
        w_frame_nxt   = '0;
        w_sub_nxt     = '0;
        if (start) begin
          w_state_nxt     = SERVE;
          w_new_round_nxt = 1'b1;
        end
      end
      SERVE: begin
        if (refresh_tick) begin
          if (r_frame == FCW'(SERVE_FRAMES - 1)) begin
            w_frame_nxt = '0;
            w_state_nxt = PLAY;
          end else begin
            w_frame_nxt = r_frame + 1'b1;
          end
        end
      end
      PLAY: begin
        // A scoring tick beats a simultaneous pause; otherwise pause freezes everything.
        if (w_pause && !(refresh_tick && w_hit)) begin
          w_state_nxt = PAUSED;
        end else if (refresh_tick) begin
          w_score1_nxt  = w_sc1;
          w_score2_nxt  = w_sc2;
          w_seconds_nxt = w_sec_dec;
          w_sub_nxt     = w_sub_adv;
          if (w_p1_hit && (w_sc1 >= w_win)) begin
            w_state_nxt  = OVER;
            w_winner_nxt = 2'd1;
            w_frame_nxt  = '0;
          end else if (w_p2_hit && (w_sc2 >= w_win)) begin
            w_state_nxt  = OVER;
            w_winner_nxt = 2'd2;
            w_frame_nxt  = '0;
          end else if (w_sec_dec == 6'd0) begin
            w_state_nxt  = OVER;
            w_winner_nxt = compare_winner(w_sc1, w_sc2);
            w_frame_nxt  = '0;
          end else if (w_hit) begin
            w_state_nxt = POINT;
          end
        end
      end
      POINT: begin
        w_new_round_nxt = 1'b1;
        w_frame_nxt     = '0;
        w_state_nxt     = SERVE;
      end
      OVER: begin
        if (refresh_tick) begin
          if (r_frame == FCW'(OVER_FRAMES - 1)) begin
            w_state_nxt   = IDLE;
            w_frame_nxt   = '0;
            w_sub_nxt     = '0;
            w_score1_nxt  = 4'd0;
            w_score2_nxt  = 4'd0;
            w_winner_nxt  = 2'd0;
            w_seconds_nxt = w_tlim;
          end else begin
            w_frame_nxt = r_frame + 1'b1;
          end
        end
      end
      PAUSED: begin
        if (w_pause) w_state_nxt = PLAY;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_score1    <= 4'd0;
      r_score2    <= 4'd0;
      r_seconds   <= 6'd0;
      r_winner    <= 2'd0;
      r_new_round <= 1'b0;
      r_frame     <= '0;
      r_sub       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_score1    <= w_score1_nxt;
      r_score2    <= w_score2_nxt;
      r_seconds   <= w_seconds_nxt;
      r_winner    <= w_winner_nxt;
      r_new_round <= w_new_round_nxt;
      r_frame     <= w_frame_nxt;
      r_sub       <= w_sub_nxt;
    end
  end

  assign state       = r_state;
  assign score1      = r_score1;
  assign score2      = r_score2;
  assign seconds     = r_seconds;
  assign winner      = r_winner;
  assign new_round   = r_new_round;
  assign ball_enable = (r_state == PLAY);
  assign game_over   = (r_state == OVER);
endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: table of opening vectors plus hand-built match sequences.
module tb_match_controller;
  localparam int SERVE_F = 60;
  localparam int OVER_F  = 180;

  logic       clk = 1'b0;
  logic       reset, refresh_tick, start;
  logic [9:0] ball_x;
  logic [3:0] win_score;
  logic [5:0] time_limit;
  logic [2:0] state;
  logic [3:0] score1, score2;
  logic [5:0] seconds;
  logic       new_round, ball_enable, game_over;
  logic [1:0] winner;
`ifdef MATCH_CTRL_PAUSE_EN
  logic       pause;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  match_controller dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start(start),
`ifdef MATCH_CTRL_PAUSE_EN
    .pause(pause),
`endif
    .ball_x(ball_x), .win_score(win_score), .time_limit(time_limit),
    .state(state), .score1(score1), .score2(score2), .seconds(seconds),
    .new_round(new_round), .ball_enable(ball_enable), .game_over(game_over),
    .winner(winner)
  );

  typedef struct {
    string      nm;
    logic       tk;
    logic       st;
    logic [9:0] bx;
    logic [2:0] e_st;
    logic [3:0] e_s1;
    logic [3:0] e_s2;
    logic [5:0] e_sec;
    logic       e_nr;
    logic       e_be;
    logic       e_go;
    logic [1:0] e_w;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic tk, input logic st, input logic [9:0] bx,
                     input logic [2:0] e_st, input logic [3:0] e_s1, input logic [3:0] e_s2,
                     input logic [5:0] e_sec, input logic e_nr, input logic e_be,
                     input logic e_go, input logic [1:0] e_w);
    vec_t v;
    v.nm = nm; v.tk = tk; v.st = st; v.bx = bx;
    v.e_st = e_st; v.e_s1 = e_s1; v.e_s2 = e_s2; v.e_sec = e_sec;
    v.e_nr = e_nr; v.e_be = e_be; v.e_go = e_go; v.e_w = e_w;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [2:0] st, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [5:0] sec, input logic nr,
                       input logic be, input logic go, input logic [1:0] w);
    n_vec++;
    if (state !== st || score1 !== s1 || score2 !== s2 || seconds !== sec ||
        new_round !== nr || ball_enable !== be || game_over !== go || winner !== w) begin
      n_bad++;
      $display("FAIL %s: got st=%0d s1=%0d s2=%0d sec=%0d nr=%0b be=%0b go=%0b w=%0d, expected st=%0d s1=%0d s2=%0d sec=%0d nr=%0b be=%0b go=%0b w=%0d",
               nm, state, score1, score2, seconds, new_round, ball_enable, game_over, winner,
               st, s1, s2, sec, nr, be, go, w);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic tk, input logic st, input logic [9:0] bx);
    @(negedge clk);
    refresh_tick = tk;
    start        = st;
    ball_x       = bx;
    @(posedge clk);
    #1;
    refresh_tick = 1'b0;
    start        = 1'b0;
`ifdef MATCH_CTRL_PAUSE_EN
    pause        = 1'b0;
`endif
  endtask

  task automatic serve(input int done, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [5:0] sec);
    for (int i = done; i < SERVE_F - 1; i++) begin
      step(1'b1, 1'b0, 10'd320);
      check("serve_hold", 3'd1, s1, s2, sec, 1'b0, 1'b0, 1'b0, 2'd0);
    end
    step(1'b1, 1'b0, 10'd320);
    check("serve_to_play", 3'd2, s1, s2, sec, 1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic begin_match(input logic [5:0] sec);
    step(1'b0, 1'b0, 10'd320);
    check("idle_load", 3'd0, 4'd0, 4'd0, sec, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 10'd320);
    check("start_pulse", 3'd1, 4'd0, 4'd0, sec, 1'b1, 1'b0, 1'b0, 2'd0);
    serve(0, 4'd0, 4'd0, sec);
  endtask

  task automatic drain_over(input logic [5:0] idle_sec);
    repeat (OVER_F) step(1'b1, 1'b0, 10'd320);
    check("over_to_idle", 3'd0, 4'd0, 4'd0, idle_sec, 1'b0, 1'b0, 1'b0, 2'd0);
  endtask

  initial begin
    reset = 1'b1; refresh_tick = 1'b0; start = 1'b0; ball_x = 10'd320;
    win_score = 4'd3; time_limit = 6'd10;
`ifdef MATCH_CTRL_PAUSE_EN
    pause = 1'b0;
`endif
    step(1'b0, 1'b0, 10'd320);
    check("reset_state", 3'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;

    add("idle_load",     1'b0, 1'b0, 10'd320, 3'd0, 4'd0, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);
    add("idle_tick_x0",  1'b1, 1'b0, 10'd0,   3'd0, 4'd0, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);
    add("start",         1'b0, 1'b1, 10'd320, 3'd1, 4'd0, 4'd0, 6'd10, 1'b1, 1'b0, 1'b0, 2'd0);
    add("nr_one_cycle",  1'b0, 1'b0, 10'd320, 3'd1, 4'd0, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);
    add("start_ignored", 1'b0, 1'b1, 10'd320, 3'd1, 4'd0, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);
    add("serve_no_score",1'b1, 1'b0, 10'd640, 3'd1, 4'd0, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);
    foreach (tbl[i]) begin
      step(tbl[i].tk, tbl[i].st, tbl[i].bx);
      check(tbl[i].nm, tbl[i].e_st, tbl[i].e_s1, tbl[i].e_s2, tbl[i].e_sec,
            tbl[i].e_nr, tbl[i].e_be, tbl[i].e_go, tbl[i].e_w);
    end
    serve(1, 4'd0, 4'd0, 6'd10);

    // Score to win for P1 with win_score=3.
    step(1'b1, 1'b0, 10'd640);
    check("p1_point", 3'd3, 4'd1, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 10'd320);
    check("point_nr", 3'd1, 4'd1, 4'd0, 6'd10, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 10'd320);
    check("point_nr_end", 3'd1, 4'd1, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);
    serve(0, 4'd1, 4'd0, 6'd10);
    step(1'b0, 1'b0, 10'd0);
    check("no_tick_no_score", 3'd2, 4'd1, 4'd0, 6'd10, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 10'd700);
    check("p1_point2", 3'd3, 4'd2, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 10'd320);
    serve(0, 4'd2, 4'd0, 6'd10);
    step(1'b1, 1'b0, 10'd640);
    check("p1_wins", 3'd4, 4'd3, 4'd0, 6'd10, 1'b0, 1'b0, 1'b1, 2'd1);
    for (int i = 0; i < OVER_F - 1; i++) begin
      step(1'b1, (i == 5), 10'd0);
      check("over_hold", 3'd4, 4'd3, 4'd0, 6'd10, 1'b0, 1'b0, 1'b1, 2'd1);
    end
    step(1'b1, 1'b0, 10'd320);
    check("over_to_idle", 3'd0, 4'd0, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);

    // Zero win_score and time_limit behave as 1.
    win_score = 4'd0; time_limit = 6'd0;
    begin_match(6'd1);
    step(1'b1, 1'b0, 10'd0);
    check("p2_wins_ws0", 3'd4, 4'd0, 4'd1, 6'd1, 1'b0, 1'b0, 1'b1, 2'd2);
    drain_over(6'd1);

    // Timer expiry with level scores is a tie.
    win_score = 4'd3; time_limit = 6'd1;
    begin_match(6'd1);
    for (int i = 0; i < 59; i++) begin
      step(1'b1, 1'b0, 10'd320);
      check("timer_run", 3'd2, 4'd0, 4'd0, 6'd1, 1'b0, 1'b1, 1'b0, 2'd0);
    end
    step(1'b1, 1'b0, 10'd320);
    check("timer_tie", 3'd4, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b1, 2'd3);
    drain_over(6'd1);

    // Timer expiry with P2 ahead.
    win_score = 4'd5;
    begin_match(6'd1);
    step(1'b1, 1'b0, 10'd0);
    check("p2_point", 3'd3, 4'd0, 4'd1, 6'd1, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 10'd320);
    serve(0, 4'd0, 4'd1, 6'd1);
    repeat (58) step(1'b1, 1'b0, 10'd320);
    check("p2_lead_run", 3'd2, 4'd0, 4'd1, 6'd1, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 10'd320);
    check("timer_p2", 3'd4, 4'd0, 4'd1, 6'd0, 1'b0, 1'b0, 1'b1, 2'd2);
    drain_over(6'd1);

    // Winning score and timer expiry on the same tick: score takes priority.
    win_score = 4'd3;
    begin_match(6'd1);
    step(1'b1, 1'b0, 10'd640);
    step(1'b0, 1'b0, 10'd320);
    serve(0, 4'd1, 4'd0, 6'd1);
    step(1'b1, 1'b0, 10'd640);
    check("sim_p1_point2", 3'd3, 4'd2, 4'd0, 6'd1, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 10'd320);
    serve(0, 4'd2, 4'd0, 6'd1);
    repeat (57) step(1'b1, 1'b0, 10'd320);
    check("sim_before", 3'd2, 4'd2, 4'd0, 6'd1, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 10'd700);
    check("sim_score_wins", 3'd4, 4'd3, 4'd0, 6'd0, 1'b0, 1'b0, 1'b1, 2'd1);
    drain_over(6'd1);

    // Reset in POINT must not leave a new_round pulse behind.
    time_limit = 6'd10;
    begin_match(6'd10);
    step(1'b1, 1'b0, 10'd640);
    check("pre_rst_point", 3'd3, 4'd1, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b1;
    step(1'b0, 1'b0, 10'd320);
    check("rst_in_point", 3'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    step(1'b0, 1'b0, 10'd320);
    check("post_rst_idle", 3'd0, 4'd0, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);

    // Reset mid-PLAY with a nonzero score.
    begin_match(6'd10);
    step(1'b1, 1'b0, 10'd0);
    step(1'b0, 1'b0, 10'd320);
    serve(0, 4'd0, 4'd1, 6'd10);
    reset = 1'b1;
    step(1'b1, 1'b0, 10'd640);
    check("rst_in_play", 3'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    step(1'b0, 1'b0, 10'd320);
    check("post_rst_idle2", 3'd0, 4'd0, 4'd0, 6'd10, 1'b0, 1'b0, 1'b0, 2'd0);

`ifdef MATCH_CTRL_PAUSE_EN
    begin_match(6'd10);
    repeat (180) step(1'b1, 1'b0, 10'd320);
    check("pre_pause", 3'd2, 4'd0, 4'd0, 6'd7, 1'b0, 1'b1, 1'b0, 2'd0);
    pause = 1'b1;
    step(1'b0, 1'b0, 10'd320);
    check("paused", 3'd5, 4'd0, 4'd0, 6'd7, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 10'd0);
      check("paused_hold", 3'd5, 4'd0, 4'd0, 6'd7, 1'b0, 1'b0, 1'b0, 2'd0);
    end
    pause = 1'b1;
    step(1'b0, 1'b0, 10'd320);
    check("resume", 3'd2, 4'd0, 4'd0, 6'd7, 1'b0, 1'b1, 1'b0, 2'd0);
    repeat (59) step(1'b1, 1'b0, 10'd320);
    check("resume_sub", 3'd2, 4'd0, 4'd0, 6'd7, 1'b0, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b0, 10'd320);
    check("resume_dec", 3'd2, 4'd0, 4'd0, 6'd6, 1'b0, 1'b1, 1'b0, 2'd0);
    pause = 1'b1;
    step(1'b1, 1'b0, 10'd0);
    check("pause_vs_score", 3'd3, 4'd0, 4'd1, 6'd6, 1'b0, 1'b0, 1'b0, 2'd0);
    pause = 1'b1;
    step(1'b0, 1'b0, 10'd320);
    check("pause_in_point", 3'd1, 4'd0, 4'd1, 6'd6, 1'b1, 1'b0, 1'b0, 2'd0);
    pause = 1'b1;
    step(1'b0, 1'b0, 10'd320);
    check("pause_in_serve", 3'd1, 4'd0, 4'd1, 6'd6, 1'b0, 1'b0, 1'b0, 2'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Pong match sequencer that sits directly downstream of the ball engine and upstream of the text/pixel renderer.
- Consumes per-frame `ball_x` and produces the values the renderer draws: registered scores, countdown seconds, `game_over` and `winner`.
- Drives the ball engine's round control: a one-cycle `new_round` pulse and a `ball_enable` hold during serve.
- Replaces ad-hoc combinational scoring with a single synchronous FSM. Updates are frame-paced by `refresh_tick`.

Parameters:
- SCREEN_W, 640, right-edge threshold; `ball_x >= SCREEN_W` is a point for player 1.
- FRAMES_PER_SEC, 60, `refresh_tick` count per countdown second.
- SERVE_FRAMES, 60, frames the ball is held before play resumes.
- OVER_FRAMES, 180, frames the game-over screen is held before returning to IDLE.

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain)
- reset  in  1  synchronous, active-high reset
- refresh_tick  in  1  one-cycle pulse per frame
- start  in  1  one-cycle pulse (debounced/one-pulsed upstream)
- ball_x  in  10  ball horizontal position from the ball engine
- win_score  in  4  points needed to win; 0 is treated as 1
- time_limit  in  6  match length in seconds; 0 is treated as 1
- state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, PAUSED=5
- score1, score2  out  4 each  player scores, saturating at 15
- seconds  out  6  remaining match seconds
- new_round  out  1  one-cycle pulse; ball engine recentres
- ball_enable  out  1  high only in PLAY
- game_over  out  1  high only in OVER
- winner  out  2  0=none, 1=P1, 2=P2, 3=tie; valid in OVER

Behaviour:
- Reset (sync, active-high): clock and reset as stated above; reset is synchronous and active-high. Mid-operation reset returns every register to its reset value on the next edge, no residual pulses.
  - Reset values: state=IDLE, score1=score2=0, seconds=0, new_round=0, ball_enable=0, game_over=0, winner=0.
  - Reset also clears the frame and second counters.
- IDLE:
  - Scores are held at 0, winner=0, and `seconds` is loaded from the effective `time_limit` every cycle.
  - `start` -> SERVE. In the same edge, `new_round` is registered high, so it is high for exactly one cycle after the transition.
  - Frame counter is cleared.
- SERVE:
  - ball_enable=0.
  - Counts `refresh_tick`s. On the SERVE_FRAMES-th tick -> PLAY.
  - Countdown is frozen.
- PLAY: ball_enable=1. All checks are made only on cycles where `refresh_tick`=1.
  - Scoring: `ball_x==0` -> score2+1; `ball_x>=SCREEN_W` -> score1+1. Increments saturate at 15.
  - Countdown: the second counter increments; at FRAMES_PER_SEC-1 it wraps to 0 and `seconds` decrements (never below 0).
  - Priority on the same tick:
    1. A score that reaches the effective win score -> OVER, winner = scorer.
    2. Otherwise, `seconds` reaching 0 -> OVER, winner by comparison (higher score wins; equal gives 3).
    3. Otherwise a plain score -> POINT.
- POINT: single-cycle state. Asserts the `new_round` register so the pulse appears one cycle later, then -> SERVE. Serve counter is cleared.
- OVER:
  - game_over=1, ball_enable=0.
  - Scores, seconds and winner are frozen; `start` is ignored.
  - After OVER_FRAMES ticks -> IDLE.
- new_round is never high for more than one consecutive cycle.
- `start` outside IDLE is ignored (except as defined under PAUSE_EN).

Optional Feature:
- MATCH_CTRL_PAUSE_EN, defined:
  - Adds input `pause` (1 bit, one-cycle pulse).
  - In PLAY, `pause` -> PAUSED. In PAUSED, ball_enable=0, the countdown and frame counters are frozen, and no scoring occurs.
  - `pause` in PAUSED -> PLAY with counters resumed exactly where they stopped.
  - `pause` in any other state is ignored.
  - If `pause` and a scoring tick coincide, scoring wins and `pause` is dropped.
- Not defined: no `pause` port; state 5 is unreachable; all other behaviour is identical.

Test Plan:
- Reset then idle: win_score=3, time_limit=10, no start -> state=0, scores=0, seconds=10 from the cycle after reset release, new_round never asserted.
- Start and serve: pulse `start` -> state=1; new_round=1 for exactly 1 cycle; ball_enable=0 for 60 ticks; state=2 on the 60th tick.
- Scoring to win: in PLAY, present ball_x=640 on a tick -> score1=1, state 3 then 1, one new_round pulse. Repeat to score1=3 -> state=4, winner=1, game_over=1. After 180 ticks -> state=0 with scores cleared.
- Timer expiry tie: time_limit=1, score1=score2=0 -> after 60 PLAY ticks seconds=0, state=4, winner=3.
- Simultaneous events: score1=2, win_score=3, seconds hitting 0 on the same tick as ball_x=700 -> winner=1 (score priority). Separately, assert reset mid-PLAY -> all outputs at reset values next cycle.
- Pause (MATCH_CTRL_PAUSE_EN): pause in PLAY with seconds=7 -> hold 300 ticks with ball_x=0, score2 unchanged, seconds=7. Pause again -> state=2 and the countdown resumes.
